// File: rtl/zybo_btn_in.sv
// Push-button conditioner for the Zybo board.
// Each channel has a 2-FF synchronizer and a debounce FSM, and produces a level, press/release strobes and a long-press strobe.
module zybo_btn_in #(
   parameter int unsigned NUM_BTN          = 4,
   parameter int unsigned DEBOUNCE_COUNT   = 2500000,
   parameter int unsigned LONG_PRESS_COUNT = 125000000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_BTN-1:0] BTN,
   output logic [NUM_BTN-1:0] BTN_LEVEL,
   output logic [NUM_BTN-1:0] BTN_PRESS,
   output logic [NUM_BTN-1:0] BTN_RELEASE,
   output logic [NUM_BTN-1:0] BTN_LONG
);

   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_COUNT);
   localparam int unsigned HCNT_W = $clog2(LONG_PRESS_COUNT);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_COUNT - 1);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_COUNT - 1);

   typedef enum logic [1:0] {
      S_LOW   = 2'd0,
      S_CHK_H = 2'd1,
      S_HIGH  = 2'd2,
      S_CHK_L = 2'd3
   } state_t;

   logic [NUM_BTN-1:0] s1;
   logic [NUM_BTN-1:0] s2;

   // Two-stage synchronizer for the asynchronous pins
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= BTN;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      state_t              state;
      logic [DCNT_W-1:0]   dcnt;
      logic [HCNT_W-1:0]   hcnt;
      logic                long_done;
      logic                level;
      logic                press;
      logic                release_q;
      logic                long_q;

      // Debounce FSM plus hold counter; the hold counter stops at its last value once the strobe has fired
      always_ff @(posedge CLK) begin
         if (RST) begin
            state     <= S_LOW;
            dcnt      <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            press     <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            if (level && !long_done) begin
               if (hcnt == HCNT_LAST) begin
                  long_q    <= 1'b1;
                  long_done <= 1'b1;
               end else begin
                  hcnt <= hcnt + HCNT_W'(1);
               end
            end

            case (state)
               S_LOW: begin
                  if (s2[i]) begin
                     state <= S_CHK_H;
                     dcnt  <= '0;
                  end
               end
               S_CHK_H: begin
                  if (!s2[i]) begin
                     state <= S_LOW;
                     dcnt  <= '0;
                  end else if (dcnt == DCNT_LAST) begin
                     state     <= S_HIGH;
                     level     <= 1'b1;
                     press     <= 1'b1;
                     hcnt      <= '0;
                     long_done <= 1'b0;
                  end else begin
                     dcnt <= dcnt + DCNT_W'(1);
                  end
               end
               S_HIGH: begin
                  if (!s2[i]) begin
                     state <= S_CHK_L;
                     dcnt  <= '0;
                  end
               end
               S_CHK_L: begin
                  if (s2[i]) begin
                     state <= S_HIGH;
                     dcnt  <= '0;
                  end else if (dcnt == DCNT_LAST) begin
                     state     <= S_LOW;
                     level     <= 1'b0;
                     release_q <= 1'b1;
                     hcnt      <= '0;
                     long_done <= 1'b0;
                  end else begin
                     dcnt <= dcnt + DCNT_W'(1);
                  end
               end
               default: begin
                  state <= S_LOW;
                  dcnt  <= '0;
               end
            endcase
         end
      end

      assign BTN_LEVEL[i]   = level;
      assign BTN_PRESS[i]   = press;
      assign BTN_RELEASE[i] = release_q;
      assign BTN_LONG[i]    = long_q;
   end

endmodule

// File: tb/tb_zybo_btn_in.sv
// Directed bench for zybo_btn_in with short debounce/long-press counts.
// Inputs change 1 time unit after the rising edge, and the outputs are sampled at that same point.
module tb_zybo_btn_in;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] BTN;
   logic [3:0] BTN_LEVEL;
   logic [3:0] BTN_PRESS;
   logic [3:0] BTN_RELEASE;
   logic [3:0] BTN_LONG;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [11:0] acc;

   zybo_btn_in #(
      .NUM_BTN         (4),
      .DEBOUNCE_COUNT  (4),
      .LONG_PRESS_COUNT(20)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN        (BTN),
      .BTN_LEVEL  (BTN_LEVEL),
      .BTN_PRESS  (BTN_PRESS),
      .BTN_RELEASE(BTN_RELEASE),
      .BTN_LONG   (BTN_LONG)
   );

   always #4 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge; collect any strobe seen into acc as {long, release, press}
   task automatic tick();
      @(posedge CLK);
      #1;
      acc = acc | {BTN_LONG, BTN_RELEASE, BTN_PRESS};
   endtask

   // The next edge is e0. No strobe may occur before edge e0+k. At e0+k the strobe must appear, and it must be gone one edge later.
   task automatic edge_check(input string tag, input int unsigned k,
                             input logic [3:0] press, input logic [3:0] rel,
                             input logic [3:0] lvl);
      acc = '0;
      repeat (k) tick();
      check({tag, "_quiet"}, 32'(acc), 32'h0);
      check({tag, "_lvl_before"}, 32'(BTN_LEVEL), 32'(lvl ^ (press | rel)));
      tick();
      check({tag, "_press"}, 32'(BTN_PRESS), 32'(press));
      check({tag, "_release"}, 32'(BTN_RELEASE), 32'(rel));
      check({tag, "_level"}, 32'(BTN_LEVEL), 32'(lvl));
      acc = '0;
      tick();
      check({tag, "_one_cycle"}, 32'(acc), 32'h0);
   endtask

   initial begin
      // 1. Reset with all buttons held
      RST = 1'b1;
      BTN = 4'hF;
      acc = '0;
      repeat (3) tick();
      check("rst_strobes", 32'(acc), 32'h0);
      check("rst_level", 32'(BTN_LEVEL), 32'h0);
      RST = 1'b0;
      edge_check("t1_press", 6, 4'hF, 4'h0, 4'hF);
      BTN = 4'h0;
      edge_check("t1_release", 6, 4'h0, 4'hF, 4'h0);

      // 2. Clean press and release on channel 0
      BTN = 4'h1;
      edge_check("t2_press", 6, 4'h1, 4'h0, 4'h1);
      BTN = 4'h0;
      edge_check("t2_release", 6, 4'h0, 4'h1, 4'h0);

      // 3. Short glitch on channel 1, then a bouncy press
      BTN = 4'h2;
      acc = '0;
      repeat (3) tick();
      BTN = 4'h0;
      repeat (10) tick();
      check("t3_glitch_strobes", 32'(acc), 32'h0);
      check("t3_glitch_level", 32'(BTN_LEVEL), 32'h0);
      acc = '0;
      BTN = 4'h2; tick();
      BTN = 4'h2; tick();
      BTN = 4'h0; tick();
      BTN = 4'h2;
      check("t3_bounce_quiet", 32'(acc), 32'h0);
      edge_check("t3_press", 6, 4'h2, 4'h0, 4'h2);
      BTN = 4'h0;
      edge_check("t3_release", 6, 4'h0, 4'h2, 4'h0);

      // 4. Long press on channel 2
      BTN = 4'h4;
      edge_check("t4_press", 6, 4'h4, 4'h0, 4'h4);
      acc = '0;
      repeat (18) tick();
      check("t4_before_long", 32'(acc), 32'h0);
      tick();
      check("t4_long", 32'(BTN_LONG), 32'h4);
      acc = '0;
      repeat (13) tick();
      check("t4_no_second_long", 32'(acc), 32'h0);
      BTN = 4'h0;
      edge_check("t4_release", 6, 4'h0, 4'h4, 4'h0);

      // 5. Channels 0 and 3 rise together; channel 3 drops after 2 cycles
      BTN = 4'h9;
      acc = '0;
      repeat (2) tick();
      BTN = 4'h1;
      check("t5_early_quiet", 32'(acc), 32'h0);
      edge_check("t5_press", 4, 4'h1, 4'h0, 4'h1);
      BTN = 4'h0;
      edge_check("t5_release", 6, 4'h0, 4'h1, 4'h0);

      // 6. Reset during a hold on channel 2
      BTN = 4'h4;
      edge_check("t6_press", 6, 4'h4, 4'h0, 4'h4);
      repeat (9) tick();
      RST = 1'b1;
      acc = '0;
      repeat (2) tick();
      check("t6_rst_strobes", 32'(acc), 32'h0);
      check("t6_rst_level", 32'(BTN_LEVEL), 32'h0);
      RST = 1'b0;
      edge_check("t6_repress", 6, 4'h4, 4'h0, 4'h4);
      acc = '0;
      repeat (18) tick();
      check("t6_before_long", 32'(acc), 32'h0);
      tick();
      check("t6_long", 32'(BTN_LONG), 32'h4);
      BTN = 4'h0;
      edge_check("t6_release", 6, 4'h0, 4'h4, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
